fcvt_itof: RTL and testbench
============================

Name: fcvt_itof

Overview:
- Pipelined int32/uint32 to IEEE-754 single-precision converter for the FPU.
- Implements fcvt.s.w and fcvt.s.wu. It is the producer-side counterpart of the float comparators: those consume float words, this block creates them from integers.
- Sits beside the other FPU units, between the integer register read stage and FPU writeback.
- 3-stage pipeline with valid/ready handshakes on both ends. A tag field passes through unchanged for writeback routing.

Parameters:
- TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  synchronous, active-low reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  32  integer operand.
- in_unsigned  input  1  1: treat in_data as uint32; 0: treat as two's-complement int32.
- in_tag  input  TAG_W  tag, returned with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  float32 result {sign, exp[7:0], mant[22:0]}.
- out_inexact  output  1  result was rounded (fflags NX).
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Handshakes:
  - Transfer on a side occurs when valid & ready are both high on a rising edge.
  - in_ready must not depend combinationally on in_valid.
  - out_valid/out_data/out_inexact/out_tag must be held stable while out_valid=1 and out_ready=0.
- Pipeline: stages S1, S2, S3, each with a valid bit v1, v2, v3. Outputs are driven directly from S3 registers.
  - en3 = ~v3 | out_ready
  - en2 = ~v2 | en3
  - en1 = ~v1 | en2
  - in_ready = en1
  - Bubbles collapse. A stage loads from its predecessor when its enable is high, and its valid bit takes the predecessor's valid.
  - Latency: 3 cycles from input transfer to out_valid when unstalled. Throughput: 1 per cycle.
- S1: sign = ~in_unsigned & in_data[31]; mag = sign ? -in_data : in_data, as 32-bit unsigned.
  - -2^31 gives mag 0x80000000, which is correct.
- S2: lz = count of leading zeros of mag (0..32); norm = mag << lz. Zero flag = (mag == 0).
- S3: rounding and packing.
  - Fields: mant = norm[30:8], guard = norm[7], sticky = |norm[6:0].
  - Round-to-nearest-even: round up when guard & (sticky | mant[0]).
  - Rounded mantissa overflow (carry out of 23 bits) sets mant = 0 and exp += 1.
  - exp = 158 - lz (+1 on carry). Range 127..159; overflow or underflow is impossible.
  - out_inexact = guard | sticky.
  - Zero input: out_data = 0x00000000 (+0), out_inexact = 0. Sign is never set for zero.
- Reset (rstn=0 on a rising edge):
  - v1, v2, v3 clear, so out_valid = 0 and in_ready = 1 in the cycle after reset.
  - out_data = 0, out_inexact = 0, out_tag = 0.
  - In-flight operations are discarded. No transfer is accepted in a reset cycle.
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle are both honoured.
  - With the pipeline full and out_ready=1, throughput stays 1/cycle.

Optional Feature:
- Macro: FCVT_ITOF_RM_EN.
- Defined:
  - Adds input port in_rm [2:0], captured with the operand and carried through the pipeline.
  - Encodings: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
  - Round-up rules:
    - RTZ: never.
    - RDN: sign & (guard | sticky).
    - RUP: ~sign & (guard | sticky).
    - RMM: guard.
  - Other in_rm codes behave as RNE.
- Not defined: no in_rm port; RNE only.
- out_inexact is identical in both builds.

Test Plan:
- Signed basics, back-to-back, out_ready=1:
  - 1 → 0x3F800000.
  - -1 (0xFFFFFFFF) → 0xBF800000.
  - 0 → 0x00000000.
  - Each NX=0; results arrive 3 cycles after the transfer, one per cycle, tags preserved in order.
- Extremes:
  - 0x80000000 signed → 0xCF000000, NX=0.
  - 0x7FFFFFFF → 0x4F000000, NX=1.
  - 0xFFFFFFFF unsigned → 0x4F800000, NX=1 (mantissa carry into exponent).
- RNE ties:
  - 16777217 → 0x4B800000, NX=1.
  - 16777219 → 0x4B800002, NX=1.
  - 16777218 → 0x4B800001, NX=0.
- Backpressure:
  - Stream 5 operands with out_ready held 0.
  - in_ready drops after 3 accepted.
  - out_data stays stable while stalled.
  - Release out_ready: all 5 emerge in order with no loss or duplication.
- Reset mid-flight:
  - Assert rstn=0 with 3 ops in flight.
  - Next cycle: out_valid=0, in_ready=1, outputs zero.
  - Next op after reset emerges alone after 3 cycles.
- With FCVT_ITOF_RM_EN:
  - 16777217 with RUP → 0x4B800001.
  - -16777217 with RDN → 0xCB800001.
  - 16777219 with RTZ → 0x4B800001.

Source files
------------

// File: rtl/fcvt_itof.sv
// fcvt_itof: 3-stage pipelined int32/uint32 -> IEEE-754 float32 converter (fcvt.s.w / fcvt.s.wu).
// Optional build macro FCVT_ITOF_RM_EN adds a per-operation rounding-mode input in_rm.
module fcvt_itof #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_unsigned,
`ifdef FCVT_ITOF_RM_EN
  input  logic [2:0]       in_rm,
`endif
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_inexact,
  output logic [TAG_W-1:0] out_tag
);

`ifdef FCVT_ITOF_RM_EN
  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;
`endif

  // Stage valid bits and stall enables
  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;
  logic en1, en2, en3;

  // S1 payload: sign and magnitude
  logic             sign1_d, sign1_q;
  logic [31:0]      mag1_d,  mag1_q;
  logic [TAG_W-1:0] tag1_q;

  // S2 payload: normalised magnitude (implicit leading one dropped)
  logic [31:0]      norm_full;
  logic [5:0]       lz2_d,   lz2_q;
  logic [30:0]      norm2_d, norm2_q;
  logic             zero2_d, zero2_q;
  logic             sign2_q;
  logic [TAG_W-1:0] tag2_q;

`ifdef FCVT_ITOF_RM_EN
  logic [2:0]       rm1_q, rm2_q;
`endif

  // S3 payload: packed result, drives the outputs directly
  logic [22:0]      mant;
  logic             guard, sticky, rnd_up;
  logic [23:0]      mant_rnd;
  logic [7:0]       exp_s3;
  logic [31:0]      data3_d, data3_q;
  logic             nx3_d,   nx3_q;
  logic [TAG_W-1:0] tag3_q;

  // Enables chain back from the output so bubbles collapse and a full
  // pipeline still moves one result per cycle when out_ready is high.
  assign en3      = ~v3_q | out_ready;
  assign en2      = ~v2_q | en3;
  assign en1      = ~v1_q | en2;
  assign in_ready = en1;

  assign v1_d = en1 ? in_valid : v1_q;
  assign v2_d = en2 ? v1_q     : v2_q;
  assign v3_d = en3 ? v2_q     : v3_q;

  // S1: two's-complement magnitude; -2^31 maps to 0x80000000 unsigned.
  assign sign1_d = ~in_unsigned & in_data[31];
  assign mag1_d  = sign1_d ? (~in_data + 32'd1) : in_data;

  // S2: leading-zero count and normalisation
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lz2_d = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (mag1_q[i]) lz2_d = 6'(31 - i);
    end
    norm_full = mag1_q << lz2_d;
    norm2_d   = norm_full[30:0];
    zero2_d   = ~norm_full[31];
  end

  // S3: rounding and packing
  always_comb begin
    mant   = norm2_q[30:8];
    guard  = norm2_q[7];
    sticky = |norm2_q[6:0];
    rnd_up = guard & (sticky | mant[0]);
`ifdef FCVT_ITOF_RM_EN
    case (rm2_q)
      RM_RTZ:  rnd_up = 1'b0;
      RM_RDN:  rnd_up = sign2_q & (guard | sticky);
      RM_RUP:  rnd_up = ~sign2_q & (guard | sticky);
      RM_RMM:  rnd_up = guard;
      default: rnd_up = guard & (sticky | mant[0]);
    endcase
`endif
    // A carry out of the mantissa leaves mant_rnd[22:0] zero and bumps the exponent.
    mant_rnd = {1'b0, mant} + {23'd0, rnd_up};
    exp_s3   = 8'd158 - {2'b00, lz2_q} + {7'd0, mant_rnd[23]};
    if (zero2_q) begin
      data3_d = 32'd0;
      nx3_d   = 1'b0;
    end else begin
      data3_d = {sign2_q, exp_s3, mant_rnd[22:0]};
      nx3_d   = guard | sticky;
    end
  end

  // Control state and the output stage carry a reset; reset wins over any transfer.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every stage sees pre-edge values.
    if (!rstn) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      data3_q <= 32'd0;
      nx3_q   <= 1'b0;
      tag3_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (en3 && v2_q) begin
        data3_q <= data3_d;
        nx3_q   <= nx3_d;
        tag3_q  <= tag2_q;
      end
    end
  end

  // NOTE: S1/S2 payload registers have no reset; their valid bits already
  // qualify them, so resetting the datapath would only cost reset routing.
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      sign1_q <= sign1_d;
      mag1_q  <= mag1_d;
      tag1_q  <= in_tag;
`ifdef FCVT_ITOF_RM_EN
      rm1_q   <= in_rm;
`endif
    end
    if (en2 && v1_q) begin
      lz2_q   <= lz2_d;
      norm2_q <= norm2_d;
      zero2_q <= zero2_d;
      sign2_q <= sign1_q;
      tag2_q  <= tag1_q;
`ifdef FCVT_ITOF_RM_EN
      rm2_q   <= rm1_q;
`endif
    end
  end

  assign out_valid   = v3_q;
  assign out_data    = data3_q;
  assign out_inexact = nx3_q;
  assign out_tag     = tag3_q;

endmodule

// File: tb/tb_fcvt_itof.sv
// tb_fcvt_itof: self-checking bench for fcvt_itof; random and directed operands against an arithmetic model.
// Exercises the in_rm port and directed rounding modes when FCVT_ITOF_RM_EN is defined.
module tb_fcvt_itof;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             in_unsigned = 1'b0;
  logic [2:0]       in_rm = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic             out_inexact;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0]      data;
    logic             nx;
    logic [TAG_W-1:0] tag;
    int               at;
  } res_t;

  res_t got_q[$];

  fcvt_itof #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_unsigned(in_unsigned),
`ifdef FCVT_ITOF_RM_EN
    .in_rm      (in_rm),
`endif
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_inexact(out_inexact),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output transfers are recorded on the falling edge; 'at' is the rising edge that completes them.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) got_q.push_back('{out_data, out_inexact, out_tag, cyc + 1});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  // Reference: exact integer arithmetic on the magnitude, rounding by remainder vs. half-ulp.
  function automatic logic [32:0] ref_cvt(input logic [31:0] x, input logic uns, input logic [2:0] rm);
    longint m, kept, rem, half;
    int     e;
    bit     s, up, nx;
    s = !uns && x[31];
    m = s ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
    if (m == 0) return 33'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      kept = m << (23 - e);
      rem  = 0;
      half = 1;
    end else begin
      kept = m >> (e - 23);
      rem  = m - (kept << (e - 23));
      half = 64'd1 << (e - 24);
    end
    nx = (rem != 0);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s && nx;
      3'd3:    up = !s && nx;
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || (rem == half && kept[0]);
    endcase
    kept = kept + longint'(up);
    if (kept == (64'd1 << 24)) begin
      kept = 64'd1 << 23;
      e++;
    end
    return {nx, s, 8'(127 + e), kept[22:0]};
  endfunction

  // Presents one operand and holds it until accepted; 'at' is the accepting rising edge.
  task automatic drive(input logic [31:0] x, input logic uns, input logic [2:0] rm,
                       input logic [TAG_W-1:0] tag, output int at);
    int n = 0;
    in_valid = 1'b1; in_data = x; in_unsigned = uns; in_rm = rm; in_tag = tag;
    at = -1;
    while (at < 0 && n < 60) begin
      @(negedge clk);
      if (in_ready) at = cyc + 1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL drive_timeout in_ready stayed 0 for operand %h", x);
    end
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (got_q.size() < n && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h expected 00000000", out_data); end
    checks++; if (out_inexact !== 1'b0) begin errors++; $display("FAIL reset_out_inexact got %b expected 0", out_inexact); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %h expected 0", out_tag); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'd1, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] want [3] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    int at [3];
    res_t r;
    out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 3; i++) drive(vals[i], 1'b0, 3'd0, TAG_W'(i + 1), at[i]);
    wait_results(3);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d expected 3", got_q.size()); end
    for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
      r = got_q.pop_front();
      checks++; if (r.data !== want[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h expected %h", i, r.data, want[i]); end
      checks++; if (r.nx !== 1'b0) begin errors++; $display("FAIL b2b_nx[%0d] got %b expected 0", i, r.nx); end
      checks++; if (r.tag !== TAG_W'(i + 1)) begin errors++; $display("FAIL b2b_tag[%0d] got %0d expected %0d", i, r.tag, i + 1); end
      checks++; if (r.at !== at[i] + 3) begin errors++; $display("FAIL b2b_latency[%0d] got edge %0d expected %0d", i, r.at, at[i] + 3); end
    end
  endtask

  task automatic test_extremes_and_ties();
    logic [31:0] x    [6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd16777217, 32'd16777219, 32'd16777218};
    logic        uns  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] want [6] = '{32'hCF00_0000, 32'h4F00_0000, 32'h4F80_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0001};
    logic        wnx  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int at;
    res_t r;
    out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 6; i++) drive(x[i], uns[i], 3'd0, TAG_W'(i + 8), at);
    wait_results(6);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL edge_count got %0d expected 6", got_q.size()); end
    for (int i = 0; i < 6 && got_q.size() > 0; i++) begin
      r = got_q.pop_front();
      checks++; if (r.data !== want[i]) begin errors++; $display("FAIL edge_data[%h] got %h expected %h", x[i], r.data, want[i]); end
      checks++; if (r.nx !== wnx[i]) begin errors++; $display("FAIL edge_nx[%h] got %b expected %b", x[i], r.nx, wnx[i]); end
      checks++; if (r.tag !== TAG_W'(i + 8)) begin errors++; $display("FAIL edge_tag[%0d] got %0d expected %0d", i, r.tag, i + 8); end
    end
  endtask

  task automatic test_random();
    localparam int N = 300;
    res_t exp_q[$];
    res_t r, e;
    logic [31:0] x;
    logic        u;
    logic [2:0]  rm;
    logic [32:0] ref_v;
    int at;
    bit done = 1'b0;
    got_q.delete();
    fork
      begin
        for (int i = 0; i < N; i++) begin
          case ($urandom_range(0, 3))
            0:       x = $urandom;
            1:       x = 32'($urandom) >> $urandom_range(0, 31);
            2:       x = (32'($urandom) & 32'hFFFF_FF00) | 32'h0000_0080;
            default: x = 32'd0 - (32'($urandom) >> $urandom_range(0, 31));
          endcase
          u = 1'($urandom_range(0, 1));
`ifdef FCVT_ITOF_RM_EN
          rm = 3'($urandom_range(0, 7));
`else
          rm = 3'd0;
`endif
          ref_v = ref_cvt(x, u, rm);
          exp_q.push_back('{ref_v[31:0], ref_v[32], TAG_W'(i), 0});
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          drive(x, u, rm, TAG_W'(i), at);
        end
        wait_results(N);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    checks++; if (got_q.size() != N) begin errors++; $display("FAIL rand_count got %0d expected %0d", got_q.size(), N); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (r.data !== e.data) begin errors++; $display("FAIL rand_data tag %0d got %h expected %h", e.tag, r.data, e.data); end
      checks++; if (r.nx !== e.nx) begin errors++; $display("FAIL rand_nx tag %0d got %b expected %b", e.tag, r.nx, e.nx); end
      checks++; if (r.tag !== e.tag) begin errors++; $display("FAIL rand_tag got %0d expected %0d", r.tag, e.tag); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [5];
    logic [32:0] ref_v;
    logic [31:0] snap_d;
    logic        snap_nx;
    logic [TAG_W-1:0] snap_t;
    bit   stable = 1'b1;
    int   k = 0;
    int   at;
    res_t r;
    for (int i = 0; i < 5; i++) vals[i] = $urandom;
    got_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 8 && k < 5; c++) begin
      in_valid = 1'b1; in_data = vals[k]; in_unsigned = 1'b0; in_rm = 3'd0; in_tag = TAG_W'(20 + k);
      @(negedge clk);
      if (in_ready) k++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (k !== 3) begin errors++; $display("FAIL bp_accepted got %0d expected 3", k); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b expected 1", out_valid); end
    snap_d = out_data; snap_nx = out_inexact; snap_t = out_tag;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== snap_d || out_inexact !== snap_nx || out_tag !== snap_t) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_stable got %h expected %h held", out_data, snap_d); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = k; i < 5; i++) drive(vals[i], 1'b0, 3'd0, TAG_W'(20 + i), at);
    wait_results(5);
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count got %0d expected 5", got_q.size()); end
    for (int i = 0; i < 5 && got_q.size() > 0; i++) begin
      r = got_q.pop_front();
      ref_v = ref_cvt(vals[i], 1'b0, 3'd0);
      checks++; if (r.data !== ref_v[31:0]) begin errors++; $display("FAIL bp_data[%0d] got %h expected %h", i, r.data, ref_v[31:0]); end
      checks++; if (r.tag !== TAG_W'(20 + i)) begin errors++; $display("FAIL bp_tag[%0d] got %0d expected %0d", i, r.tag, 20 + i); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [32:0] ref_v;
    int at;
    res_t r;
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive($urandom, 1'b0, 3'd0, TAG_W'(i), at);
    rstn = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_1234; in_unsigned = 1'b0; in_tag = '1;
    @(posedge clk); #1;
    rstn = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b expected 1", in_ready); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rstmid_out_data got %h expected 00000000", out_data); end
    checks++; if (out_inexact !== 1'b0 || out_tag !== '0) begin errors++; $display("FAIL rstmid_nx_tag got %b/%0d expected 0/0", out_inexact, out_tag); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_discard got %0d results expected 0", got_q.size()); end
    drive(32'd0 - 32'd12345, 1'b0, 3'd0, TAG_W'(7), at);
    wait_results(1);
    ref_v = ref_cvt(32'd0 - 32'd12345, 1'b0, 3'd0);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      checks++; if (r.data !== ref_v[31:0]) begin errors++; $display("FAIL rstmid_data got %h expected %h", r.data, ref_v[31:0]); end
      checks++; if (r.at !== at + 3) begin errors++; $display("FAIL rstmid_latency got edge %0d expected %0d", r.at, at + 3); end
      checks++; if (r.tag !== TAG_W'(7)) begin errors++; $display("FAIL rstmid_tag got %0d expected 7", r.tag); end
    end
  endtask

`ifdef FCVT_ITOF_RM_EN
  task automatic test_rm();
    logic [31:0] x    [4] = '{32'd16777217, 32'd0 - 32'd16777217, 32'd16777219, 32'd16777217};
    logic [2:0]  rm   [4] = '{3'b011, 3'b010, 3'b001, 3'b100};
    logic [31:0] want [4] = '{32'h4B80_0001, 32'hCB80_0001, 32'h4B80_0001, 32'h4B80_0001};
    int at;
    res_t r;
    out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) drive(x[i], 1'b0, rm[i], TAG_W'(i), at);
    wait_results(4);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL rm_count got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      r = got_q.pop_front();
      checks++; if (r.data !== want[i]) begin errors++; $display("FAIL rm_data[%0d] got %h expected %h", i, r.data, want[i]); end
      checks++; if (r.nx !== 1'b1) begin errors++; $display("FAIL rm_nx[%0d] got %b expected 1", i, r.nx); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_extremes_and_ties();
    test_backpressure();
    test_reset_midflight();
    test_random();
`ifdef FCVT_ITOF_RM_EN
    test_rm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
